// File: rtl/ahb_ram_slave_pkg.sv
// Shared AHB codes and FSM state type for the AHB RAM slave.
package ahb_ram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // SEQ is handled exactly like NONSEQ, so only "is this a real beat" matters.
    function automatic logic transfer_req(input logic [1:0] htrans);
        logic req;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: req = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: req = 1'b1;
            default: req = 1'b0;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/ahb_be_decode.sv
// Combinational byte-enable and alignment-error decode for one AHB beat.
module ahb_be_decode
    import ahb_ram_slave_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       misalign
);

    // Lane select from size and low address bits; oversize or unaligned flags an error.
    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            HSIZE_WORD: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite slave in front of a single-port synchronous word RAM.
//
// state       | meaning
// ST_IDLE     | no data phase pending; ready/OKAY
// ST_WR       | write data phase; wait cycles, then strobe RAM and complete
// ST_RD_ISSUE | read strobe to RAM; bus held off
// ST_RD_WAIT  | extra wait cycles, last cycle returns ram_rdata
// ST_ERR1     | first ERROR cycle (not ready)
// ST_ERR2     | second ERROR cycle (ready)
module ahb_ram_slave
    import ahb_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic                  write_q, write_d;

    logic [3:0] dec_be;
    logic       dec_err;
    logic       accept;
    logic       done;

    // Burst type and aliased upper address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HADDR[31:ADDR_WIDTH+2]};

    ahb_be_decode u_be_decode (
        .hsize    (HSIZE),
        .addr_lo  (HADDR[1:0]),
        .be       (dec_be),
        .misalign (dec_err)
    );

    assign accept    = HSEL & transfer_req(HTRANS) & HREADY;
    assign ram_addr  = addr_q;
    assign ram_wdata = HWDATA;
    assign ram_be    = ram_ce ? be_q : 4'b0000;

    // State register, wait counter and data-phase latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // Next state, bus responses and RAM strobes; a new address phase is taken on any completing cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        be_d      = be_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'h0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: done = 1'b1;
            ST_WR: begin
                if (cnt_q != 2'd0) begin
                    HREADYOUT = 1'b0;
                    cnt_d     = cnt_q - 2'd1;
                end else begin
                    ram_ce = 1'b1;
                    ram_we = 1'b1;
                    done   = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                ram_ce    = 1'b1;
                HREADYOUT = 1'b0;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q != 2'd0) begin
                    HREADYOUT = 1'b0;
                    cnt_d     = cnt_q - 2'd1;
                end else begin
                    HRDATA = ram_rdata;
                    done   = 1'b1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = HRESP_ERROR;
                done  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            if (accept) begin
                addr_d  = HADDR[ADDR_WIDTH+1:2];
                be_d    = dec_be;
                write_d = HWRITE;
                cnt_d   = WS;
                if (dec_err)
                    state_d = ST_ERR1;
                else if (HWRITE)
                    state_d = ST_WR;
                else
                    state_d = ST_RD_ISSUE;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Randomized bench for ahb_ram_slave: two instances (0 and 2 wait states), each with a RAM and a reference memory.
module tb_ahb_ram_slave;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     [2];
    logic          hsel      [2];
    logic [31:0]   haddr     [2];
    logic [1:0]    htrans    [2];
    logic [2:0]    hsize     [2];
    logic [2:0]    hburst    [2];
    logic          hwrite    [2];
    logic [31:0]   hwdata    [2];
    logic          hready    [2];
    logic          hready_low[2];
    logic          hreadyout [2];
    logic [1:0]    hresp     [2];
    logic [31:0]   hrdata    [2];
    logic          ram_ce    [2];
    logic          ram_we    [2];
    logic [AW-1:0] ram_addr  [2];
    logic [3:0]    ram_be    [2];
    logic [31:0]   ram_wdata [2];
    logic [31:0]   ram_rdata [2];

    bit [31:0] ram_mem [2][DEPTH];
    bit [31:0] ref_mem [2][DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] b_addr [$];
    logic [2:0]  b_size [$];
    logic        b_write[$];
    logic [31:0] b_wdata[$];
    int          b_gap  [$];

    assign hready[0] = hreadyout[0] & ~hready_low[0];
    assign hready[1] = hreadyout[1] & ~hready_low[1];

    ahb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
        .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
        .ram_ce(ram_ce[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_be(ram_be[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    ahb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
        .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
        .ram_ce(ram_ce[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_be(ram_be[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // Synchronous RAM: byte-masked write, registered read held until the next strobe.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        always @(posedge clk) begin
            if (ram_ce[g]) begin
                if (ram_we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be[g][b])
                            ram_mem[g][ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
                end else begin
                    ram_rdata[g] <= ram_mem[g][ram_addr[g]];
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic beat_err(input logic [2:0] size, input logic [31:0] a);
        return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] beat_be(input logic [2:0] size, input logic [31:0] a);
        case (size)
            3'd0: return 4'(1 << a[1:0]);
            3'd1: return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    task automatic add_beat(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                            input logic [31:0] wd, input int gap);
        b_addr.push_back(a);
        b_size.push_back(sz);
        b_write.push_back(wr);
        b_wdata.push_back(wd);
        b_gap.push_back(gap);
    endtask

    task automatic add_random(input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        for (int i = 0; i < n; i++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 3'd1) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
            end
            add_beat(a, sz, 1'($urandom_range(0, 1)), $urandom,
                     $urandom_range(0, 1) ? 0 : $urandom_range(1, 3));
        end
    endtask

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        haddr[d]  = 32'h0;
        hsize[d]  = 3'd0;
        hburst[d] = 3'd0;
        hwrite[d] = 1'b0;
        hwdata[d] = 32'h0;
    endtask

    task automatic check_reset_outputs(input int d);
        check_val("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
        check_val("rst_hresp", 32'(hresp[d]), 32'd0);
        check_val("rst_hrdata", hrdata[d], 32'd0);
        check_val("rst_ram_ce", 32'(ram_ce[d]), 32'd0);
        check_val("rst_ram_we", 32'(ram_we[d]), 32'd0);
        check_val("rst_ram_be", 32'(ram_be[d]), 32'd0);
    endtask

    // Pipelined AHB master over the queued beats; every data phase is checked
    // against the reference memory. Entered and left at posedge+1.
    task automatic run_seq(input int d);
        int n = b_addr.size();
        int nxt = 0, cur = -1, waits = 0, strobes = 0, cyc = 0;
        int ws = (d == 0) ? 0 : 2;
        int exp_waits;
        logic drove_beat, gap_spent, e;
        logic [AW-1:0] widx;
        gap_spent = 1'b0;
        while (nxt < n || cur >= 0) begin
            cyc++;
            if (cyc > 20 * n + 50) begin
                check_val("seq_timeout", 32'(cyc), 32'(20 * n + 50));
                break;
            end
            drove_beat = 1'b0;
            hburst[d]  = 3'($urandom);
            if (nxt < n && b_gap[nxt] != 0 && !gap_spent) begin
                hsel[d]   = (b_gap[nxt] != 3);
                htrans[d] = (b_gap[nxt] == 1) ? 2'b00 : (b_gap[nxt] == 2) ? 2'b01 : 2'b10;
                haddr[d]  = $urandom;
                hsize[d]  = 3'd2;
                hwrite[d] = 1'($urandom_range(0, 1));
            end else if (nxt < n) begin
                hsel[d]    = 1'b1;
                htrans[d]  = $urandom_range(0, 1) ? 2'b11 : 2'b10;
                haddr[d]   = b_addr[nxt];
                hsize[d]   = b_size[nxt];
                hwrite[d]  = b_write[nxt];
                drove_beat = 1'b1;
            end else begin
                hsel[d]   = 1'b0;
                htrans[d] = 2'b00;
                haddr[d]  = $urandom;
            end
            hwdata[d] = (cur >= 0) ? b_wdata[cur] : $urandom;

            @(negedge clk);
            if (cur >= 0) begin
                e    = beat_err(b_size[cur], b_addr[cur]);
                widx = b_addr[cur][AW+1:2];
                check_val("hresp", 32'(hresp[d]), e ? 32'd1 : 32'd0);
                if (ram_ce[d]) begin
                    strobes++;
                    check_val("ram_we", 32'(ram_we[d]), 32'(b_write[cur]));
                    check_val("ram_addr", 32'(ram_addr[d]), 32'(widx));
                    if (b_write[cur]) begin
                        check_val("ram_be", 32'(ram_be[d]), 32'(beat_be(b_size[cur], b_addr[cur])));
                        check_val("ram_wdata", ram_wdata[d], b_wdata[cur]);
                        check_val("wr_strobe_slot", 32'(hreadyout[d]), 32'd1);
                    end else begin
                        check_val("rd_strobe_slot", 32'(waits), 32'd0);
                    end
                end
                if (hreadyout[d]) begin
                    exp_waits = e ? 1 : (b_write[cur] ? ws : 1 + ws);
                    check_val("wait_cycles", 32'(waits), 32'(exp_waits));
                    check_val("strobe_count", 32'(strobes), e ? 32'd0 : 32'd1);
                    if (!e && !b_write[cur])
                        check_val("hrdata", hrdata[d], ref_mem[d][widx]);
                    else
                        check_val("hrdata_zero", hrdata[d], 32'd0);
                    if (!e && b_write[cur])
                        for (int b = 0; b < 4; b++)
                            if (beat_be(b_size[cur], b_addr[cur])[b])
                                ref_mem[d][widx][8*b +: 8] = b_wdata[cur][8*b +: 8];
                end else begin
                    waits++;
                    check_val("hrdata_zero", hrdata[d], 32'd0);
                end
            end else begin
                check_val("idle_ready", 32'(hreadyout[d]), 32'd1);
                check_val("idle_resp", 32'(hresp[d]), 32'd0);
                check_val("idle_ce", 32'(ram_ce[d]), 32'd0);
                check_val("idle_hrdata", hrdata[d], 32'd0);
            end
            if (hready[d]) begin
                if (drove_beat) begin
                    cur = nxt;
                    nxt++;
                    gap_spent = 1'b0;
                end else begin
                    cur = -1;
                    if (nxt < n && b_gap[nxt] != 0) gap_spent = 1'b1;
                end
                waits   = 0;
                strobes = 0;
            end
            @(posedge clk); #1;
        end
        drive_idle(d);
        b_addr.delete();
        b_size.delete();
        b_write.delete();
        b_wdata.delete();
        b_gap.delete();
    endtask

    task automatic directed_set();
        add_beat(32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 0);
        add_beat(32'h10, 3'd2, 1'b0, 32'h0, 0);
        add_beat(32'h13, 3'd0, 1'b1, 32'hAA00_0000, 0);
        add_beat(32'h12, 3'd1, 1'b1, 32'h5566_0000, 0);
        add_beat(32'h10, 3'd2, 1'b0, 32'h0, 0);
        add_beat(32'h01, 3'd1, 1'b0, 32'h0, 0);
        add_beat(32'h20, 3'd2, 1'b1, 32'hCAFE_F00D, 0);
        add_beat(32'h20, 3'd2, 1'b0, 32'h0, 0);
        add_beat(32'h7777_0020, 3'd2, 1'b0, 32'h0, 0);
        add_beat(32'h24, 3'd4, 1'b1, 32'h1111_1111, 0);
        add_beat(32'h24, 3'd2, 1'b0, 32'h0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]      = 1'b0;
            hready_low[d] = 1'b0;
            drive_idle(d);
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Zero wait states: directed then random traffic, first beat right after reset release.
        directed_set();
        add_random(60);
        run_seq(0);

        // HREADY low while idle must not start a transfer.
        hready_low[0] = 1'b1;
        hsel[0]   = 1'b1;
        htrans[0] = 2'b10;
        hwrite[0] = 1'b1;
        haddr[0]  = 32'h30;
        hsize[0]  = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("hrlow_ready", 32'(hreadyout[0]), 32'd1);
            check_val("hrlow_ce", 32'(ram_ce[0]), 32'd0);
            @(posedge clk); #1;
        end
        drive_idle(0);
        hready_low[0] = 1'b0;
        @(negedge clk);
        check_val("hrlow_noacc", 32'(ram_ce[0]), 32'd0);
        @(posedge clk); #1;

        // Two wait states.
        directed_set();
        add_random(40);
        run_seq(1);

        // Reset during a write wait cycle: beat abandoned, RAM untouched.
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h10; hsize[1] = 3'd2; hwrite[1] = 1'b1;
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 32'h1234_5678;
        @(negedge clk);
        check_val("abort_wr_wait", 32'(hreadyout[1]), 32'd0);
        #1 rst_n[1] = 1'b0;
        #1;
        check_reset_outputs(1);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("abort_no_write", ram_mem[1][4], ref_mem[1][4]);

        // Reset during RD_WAIT: ready and zero data immediately.
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h10; hsize[1] = 3'd2; hwrite[1] = 1'b0;
        @(posedge clk); #1;
        drive_idle(1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_rd_wait", 32'(hreadyout[1]), 32'd0);
        #1 rst_n[1] = 1'b0;
        #1;
        check_reset_outputs(1);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;

        // Traffic must resume from the first edge after reset release.
        add_beat(32'h10, 3'd2, 1'b0, 32'h0, 0);
        add_random(20);
        run_seq(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_ram_slave.md
AHB_RAM_SLAVE -- requirements
Module: ahb_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, word-address bits of attached RAM (64 KiB).
REQ-002 Parameter WAIT_STATES, default 0, range 0..3, extra wait cycles added to every accepted transfer.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 HSEL  in  1  slave select from decoder.
REQ-006 HADDR  in  32  transfer address.
REQ-007 HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 HSIZE  in  3  byte=000, half=001, word=010.
REQ-009 HBURST  in  3  burst type; ignored.
REQ-010 HWRITE  in  1  1=write, 0=read.
REQ-011 HWDATA  in  32  write data, valid in data phase.
REQ-012 HREADY  in  1  bus-wide ready; address phase sampled only when high.
REQ-013 HREADYOUT  out  1  slave ready; low inserts wait state.
REQ-014 HRESP  out  2  OKAY=00, ERROR=01.
REQ-015 HRDATA  out  32  read data, full word, no lane shifting.
REQ-016 ram_ce, ram_we  out  1 each  RAM strobe and write enable.
REQ-017 ram_addr  out  ADDR_WIDTH  word address = HADDR[ADDR_WIDTH+1:2]; higher bits ignored (aliasing).
REQ-018 ram_be  out  4  byte enables; ram_wdata out 32; ram_rdata in 32, valid cycle after read strobe, held until next strobe.

Function
REQ-019 Transfer accepted when HSEL & HTRANS[1] & HREADY at clock edge; address, write, be, size registered into data-phase latch.
REQ-020 IDLE/BUSY or HSEL=0 with HREADY=1: next cycle zero-wait OKAY, no RAM access.
REQ-021 SEQ treated exactly as NONSEQ; every beat decoded independently.
REQ-022 Byte enables: byte -> 1<<HADDR[1:0]; half -> HADDR[1]?1100:0011; word -> 1111.
REQ-023 Error when HSIZE>010, half with HADDR[0]=1, or word with HADDR[1:0]!=00.
REQ-024 States: IDLE, WR, RD_ISSUE, RD_WAIT, ERR1, ERR2.
REQ-025 Write: WR state held WAIT_STATES cycles with HREADYOUT=0; final WR cycle drives ram_ce=1, ram_we=1, ram_be, ram_wdata=HWDATA, HREADYOUT=1, HRESP=OKAY.
REQ-026 Read: RD_ISSUE drives ram_ce=1, ram_we=0, HREADYOUT=0; RD_WAIT counts WAIT_STATES cycles with HREADYOUT=0; final RD_WAIT cycle HREADYOUT=1, HRDATA=ram_rdata; read latency = 1+WAIT_STATES wait states.
REQ-027 HRDATA=0 in all cycles except the read-completion cycle.
REQ-028 Error: ERR1 HREADYOUT=0, HRESP=01; ERR2 HREADYOUT=1, HRESP=01; no RAM strobe; then sample as normal.
REQ-029 New address phase sampled in any cycle with HREADY=1, including final WR/RD/ERR2 cycle; back-to-back transfers have no idle gap.
REQ-030 Write followed by read to same word: read returns new data (write strobe precedes read strobe by one cycle).
REQ-031 Wait-state counter 2 bits, loaded with WAIT_STATES on acceptance, decrements to 0, no wrap.
REQ-032 HREADY=0 while this slave idle: no acceptance, outputs hold OKAY/ready.

Reset
REQ-033 On rst_n low: state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, ram_ce=0, ram_we=0, ram_be=0, counter 0, data-phase latch cleared.
REQ-034 Reset mid-transfer abandons it; no RAM write occurs for the abandoned beat.
REQ-035 First transfer accepted on first edge after rst_n deasserts.

Structure
REQ-036 HTRANS, HSIZE, HRESP codes in shared yadan_defs.v constants.
REQ-037 Single sub-module ahb_be_decode: HSIZE+HADDR[1:0] -> ram_be and misalign error, combinational.

Verification
REQ-038 WAIT_STATES=0, word write 0xDEADBEEF to 0x10 then read 0x10 -> write zero-wait, read one wait, HRDATA=0xDEADBEEF, HRESP=00.
REQ-039 Byte write 0xAA at 0x13 -> ram_be=1000; half write at 0x12 -> ram_be=1100.
REQ-040 Half read at 0x01 -> ERR1 (HREADYOUT=0, HRESP=01), ERR2 (HREADYOUT=1, HRESP=01), ram_ce never high.
REQ-041 WAIT_STATES=2, word write -> HREADYOUT low 2 cycles; word read -> low 3 cycles, data correct.
REQ-042 Back-to-back NONSEQ write 0x20 / read 0x20 -> read returns written word, no idle cycle between.
REQ-043 rst_n asserted during RD_WAIT -> HREADYOUT=1, HRDATA=0 immediately, no RAM write.
